universal_register: RTL and testbench



---
 rtl/universal_register.sv | 109 ++++++++++
 tb/tb_universal_register.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_register.sv
// Parametrised multi-mode storage register: hold, load, shift, rotate,
// increment, decrement and clear, with registered carry/borrow and zero flags.
module universal_register #(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RESET_Q  = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_ROL  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             carry_r;
    logic             carry_nxt_s;
    logic             zero_r;
    logic             zero_nxt_s;

    // Next-state selection; any unrecognised or disabled cycle falls back to hold.
    always_comb begin
        q_nxt_s     = q_r;
        carry_nxt_s = carry_r;
        if (en) begin
            case (op_e'(op))
                OP_HOLD: begin
                    q_nxt_s     = q_r;
                    carry_nxt_s = carry_r;
                end
                OP_LOAD: begin
                    q_nxt_s     = d;
                    carry_nxt_s = 1'b0;
                end
                OP_SHL: begin
                    q_nxt_s     = {q_r[WIDTH-2:0], ser_in};
                    carry_nxt_s = q_r[WIDTH-1];
                end
                OP_SHR: begin
                    q_nxt_s     = {ser_in, q_r[WIDTH-1:1]};
                    carry_nxt_s = q_r[0];
                end
                OP_INC: begin
                    q_nxt_s     = q_r + ONE;
                    carry_nxt_s = (q_r == ALL_ONE);
                end
                OP_DEC: begin
                    q_nxt_s     = q_r - ONE;
                    carry_nxt_s = (q_r == ALL_ZERO);
                end
                OP_ROL: begin
                    q_nxt_s     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    carry_nxt_s = q_r[WIDTH-1];
                end
                OP_CLR: begin
                    q_nxt_s     = ALL_ZERO;
                    carry_nxt_s = 1'b0;
                end
                default: begin
                    q_nxt_s     = q_r;
                    carry_nxt_s = carry_r;
                end
            endcase
        end else begin
            q_nxt_s     = q_r;
            carry_nxt_s = carry_r;
        end
        // Derived from the next value so the flag always matches q on the same cycle.
        zero_nxt_s = (q_nxt_s == ALL_ZERO);
    end

    // State register with asynchronous reset to the programmed value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= RESET_Q;
            carry_r <= 1'b0;
            zero_r  <= (RESET_Q == ALL_ZERO);
        end else begin
            q_r     <= q_nxt_s;
            carry_r <= carry_nxt_s;
            zero_r  <= zero_nxt_s;
        end
    end

    assign q     = q_r;
    assign carry = carry_r;
    assign zero  = zero_r;

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register at WIDTH 8, 2 and 16, all driven
// with shared control and checked against an arithmetic reference model.
module tb_universal_register;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           INC  = 3'd4, DEC  = 3'd5, ROL = 3'd6, CLR = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic        ser_in;
    logic [7:0]  d_a;
    logic [1:0]  d_b;
    logic [15:0] d_c;
    logic [7:0]  q_a;
    logic [1:0]  q_b;
    logic [15:0] q_c;
    logic        carry_a, carry_b, carry_c;
    logic        zero_a, zero_b, zero_c;

    universal_register #(.WIDTH(8), .RESET_VALUE(64'hA5)) dut_a (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d_a), .ser_in(ser_in),
        .q(q_a), .carry(carry_a), .zero(zero_a));

    universal_register #(.WIDTH(2), .RESET_VALUE(64'h5)) dut_b (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d_b), .ser_in(ser_in),
        .q(q_b), .carry(carry_b), .zero(zero_b));

    universal_register #(.WIDTH(16), .RESET_VALUE(64'h1234)) dut_c (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d_c), .ser_in(ser_in),
        .q(q_c), .carry(carry_c), .zero(zero_c));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q [3];
        logic        c [3];
        logic        z [3];
    } exp_t;

    exp_t        sb[$];
    int          wv [3] = '{8, 2, 16};
    logic [15:0] rv [3] = '{16'hA5, 16'h1, 16'h1234};
    logic [15:0] mq [3];
    logic        mc [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference behaviour written directly from the operation table.
    function automatic logic [16:0] model_next(int w, logic [15:0] qv, logic cv, logic e,
                                               logic [2:0] o, logic [15:0] dv, logic s);
        longint unsigned m  = (64'd1 << w) - 64'd1;
        longint unsigned x  = {48'd0, qv};
        longint unsigned r  = x;
        logic            rc = cv;
        if (e) begin
            case (o)
                LOAD:    begin r = {48'd0, dv} & m; rc = 1'b0; end
                SHL:     begin r = ((x << 1) | {63'd0, s}) & m; rc = x[w-1]; end
                SHR:     begin r = (x >> 1) | ({63'd0, s} << (w - 1)); rc = x[0]; end
                INC:     begin r = (x + 64'd1) & m; rc = (x == m); end
                DEC:     begin r = (x - 64'd1) & m; rc = (x == 64'd0); end
                ROL:     begin r = ((x << 1) | (x >> (w - 1))) & m; rc = x[w-1]; end
                CLR:     begin r = 64'd0; rc = 1'b0; end
                default: begin r = x; rc = cv; end
            endcase
        end
        return {rc, r[15:0]};
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.q[i] = mq[i];
            e.c[i] = mc[i];
            e.z[i] = (mq[i] == 16'd0);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = rv[i];
            mc[i] = 1'b0;
        end
    endtask

    // One clocked operation: expected response is queued at the capturing edge.
    task automatic step(input logic e, input logic [2:0] o, input logic [15:0] da,
                        input logic [15:0] db, input logic [15:0] dc, input logic s);
        logic [15:0] dv [3];
        logic [16:0] r;
        en = e; op = o; ser_in = s;
        d_a = da[7:0]; d_b = db[1:0]; d_c = dc;
        dv[0] = da; dv[1] = db; dv[2] = dc;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            r = model_next(wv[i], mq[i], mc[i], e, o, dv[i], s);
            mq[i] = r[15:0];
            mc[i] = r[16];
        end
        sb.push_back(snapshot());
        #1;
    endtask

    task automatic op_all(input logic [2:0] o, input logic s);
        step(1'b1, o, 16'd0, 16'd0, 16'd0, s);
    endtask

    // Reset raised between edges while INC is pending; checked before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        en = 1'b1; op = INC;
        model_reset();
        sb.push_back(snapshot());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle and after any reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_w8",      {8'd0, q_a},       e.q[0]);
                chk("carry_w8",  {15'd0, carry_a},  {15'd0, e.c[0]});
                chk("zero_w8",   {15'd0, zero_a},   {15'd0, e.z[0]});
                chk("q_w2",      {14'd0, q_b},      e.q[1]);
                chk("carry_w2",  {15'd0, carry_b},  {15'd0, e.c[1]});
                chk("zero_w2",   {15'd0, zero_b},   {15'd0, e.z[1]});
                chk("q_w16",     q_c,               e.q[2]);
                chk("carry_w16", {15'd0, carry_c},  {15'd0, e.c[2]});
                chk("zero_w16",  {15'd0, zero_c},   {15'd0, e.z[2]});
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b1; en = 1'b0; op = HOLD; ser_in = 1'b0;
        d_a = 8'd0; d_b = 2'd0; d_c = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(snapshot());
        rst = 1'b0;

        // Mid-stream reset and first op after release.
        op_all(INC, 1'b0);
        op_all(INC, 1'b0);
        async_reset();
        op_all(INC, 1'b0);

        // Wrap around all-ones, then borrow back.
        step(1'b1, LOAD, 16'hFE, 16'h2, 16'hFFFE, 1'b0);
        op_all(INC, 1'b0);
        op_all(INC, 1'b0);
        op_all(DEC, 1'b0);

        // Shifts with serial input.
        step(1'b1, LOAD, 16'h81, 16'h2, 16'h8001, 1'b0);
        op_all(SHL, 1'b0);
        op_all(SHR, 1'b1);
        op_all(SHR, 1'b0);
        step(1'b1, LOAD, 16'h81, 16'h1, 16'h8001, 1'b0);
        op_all(SHL, 1'b1);

        // Full rotation.
        step(1'b1, LOAD, 16'h80, 16'h2, 16'h8000, 1'b0);
        for (int i = 0; i < 16; i++) op_all(ROL, 1'b1);

        // Enable gating and explicit hold after a carry.
        step(1'b1, LOAD, 16'hFF, 16'h3, 16'hFFFF, 1'b0);
        op_all(INC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, CLR, 16'h3C, 16'h3C, 16'h3C, 1'b1);
        op_all(HOLD, 1'b1);
        op_all(CLR, 1'b1);
        op_all(DEC, 1'b0);

        // Randomised operations with an occasional reset.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) async_reset();
            step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        drain = 0;
        while (sb.size() > 0 && drain < 5) begin
            @(negedge clk);
            drain++;
        end
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
